eightb_div_seq: RTL and testbench



---
 rtl/eightb_div_seq.sv | 154 +++++++++++++++
 tb/tb_eightb_div_seq.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/eightb_div_seq.sv
// Sequential dual-rail 16/8 restoring divider: decodes a dual-rail product word
// back into an 8-bit quotient and remainder, one quotient bit per cycle.
module eightb_div_seq (
`ifdef USE_POWER_PINS
    input  logic        vdd,
    input  logic        vss,
`endif
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] p,
    input  logic [15:0] p_not,
    input  logic [7:0]  b,
    input  logic [7:0]  b_not,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  q,
    output logic [7:0]  q_not,
    output logic [7:0]  r,
    output logic [7:0]  r_not,
    output logic        err_rail,
    output logic        err_div0,
    output logic        err_ovf,
    output logic [1:0]  dbg_state
);

    // Handshake: a word transfers on any rising edge where valid && ready are
    // both high; valid never depends on ready, and once raised, out_valid and
    // the result fields hold steady until the transfer completes.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        CALC  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state;
    logic [15:0] p_reg;
    logic [15:0] pn_reg;
    logic [7:0]  b_reg;
    logic [7:0]  bn_reg;
    logic [7:0]  rem;
    logic [7:0]  quo;
    logic [2:0]  cnt;

    logic        rail_bad;
    logic        div0;
    logic        ovf;
    logic        p_bit;
    logic [8:0]  rem_sh;
    logic        fits;
    logic [7:0]  rem_nx;
    logic [7:0]  quo_nx;

    // A rail pair is healthy only when its two bits differ.
    assign rail_bad = ~&{p_reg ^ pn_reg, b_reg ^ bn_reg};
    assign div0     = (b_reg == 8'd0);
    assign ovf      = (p_reg[15:8] >= b_reg);

    // One restoring step; the low dividend byte is consumed MSB-first.
    assign p_bit  = p_reg[3'd7 - cnt];
    assign rem_sh = {rem, p_bit};
    assign fits   = (rem_sh >= {1'b0, b_reg});
    assign rem_nx = fits ? 8'(rem_sh - {1'b0, b_reg}) : rem_sh[7:0];
    assign quo_nx = {quo[6:0], fits};

    assign in_ready  = (state == IDLE) && !rst;
    assign q_not     = ~q;
    assign r_not     = ~r;
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            p_reg     <= 16'd0;
            pn_reg    <= 16'd0;
            b_reg     <= 8'd0;
            bn_reg    <= 8'd0;
            rem       <= 8'd0;
            quo       <= 8'd0;
            cnt       <= 3'd0;
            out_valid <= 1'b0;
            q         <= 8'd0;
            r         <= 8'd0;
            err_rail  <= 1'b0;
            err_div0  <= 1'b0;
            err_ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        p_reg  <= p;
                        pn_reg <= p_not;
                        b_reg  <= b;
                        bn_reg <= b_not;
                        state  <= CHECK;
                    end
                end
                CHECK: begin
                    if (rail_bad) begin
                        err_rail  <= 1'b1;
                        out_valid <= 1'b1;
                        q         <= 8'd0;
                        r         <= 8'd0;
                        state     <= DONE;
                    end else if (div0) begin
                        err_div0  <= 1'b1;
                        out_valid <= 1'b1;
                        q         <= 8'd0;
                        r         <= 8'd0;
                        state     <= DONE;
                    end else if (ovf) begin
                        err_ovf   <= 1'b1;
                        out_valid <= 1'b1;
                        q         <= 8'd0;
                        r         <= 8'd0;
                        state     <= DONE;
                    end else begin
                        rem   <= p_reg[15:8];
                        quo   <= 8'd0;
                        cnt   <= 3'd0;
                        state <= CALC;
                    end
                end
                CALC: begin
                    rem <= rem_nx;
                    quo <= quo_nx;
                    cnt <= cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        q         <= quo_nx;
                        r         <= rem_nx;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        q         <= 8'd0;
                        r         <= 8'd0;
                        err_rail  <= 1'b0;
                        err_div0  <= 1'b0;
                        err_ovf   <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_eightb_div_seq.sv
// Directed bench for eightb_div_seq: hand-computed quotient/remainder vectors,
// error priority, latency, backpressure and mid-operation reset.
module tb_eightb_div_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] p;
    logic [15:0] p_not;
    logic [7:0]  b;
    logic [7:0]  b_not;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  q;
    logic [7:0]  q_not;
    logic [7:0]  r;
    logic [7:0]  r_not;
    logic        err_rail;
    logic        err_div0;
    logic        err_ovf;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    // {ovf, div0, rail, q, r}
    logic [18:0] exp_q[$];

    eightb_div_seq dut (
`ifdef USE_POWER_PINS
        .vdd       (1'b1),
        .vss       (1'b0),
`endif
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .p         (p),
        .p_not     (p_not),
        .b         (b),
        .b_not     (b_not),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q         (q),
        .q_not     (q_not),
        .r         (r),
        .r_not     (r_not),
        .err_rail  (err_rail),
        .err_div0  (err_div0),
        .err_ovf   (err_ovf),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Count edges from the accept edge until out_valid is seen at a negedge.
    task automatic wait_result(output int lat);
        lat = 0;
        @(negedge clk);
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("result_timeout", {31'd0, out_valid}, 32'd1);
    endtask

    task automatic check_result();
        logic [18:0] e;
        logic [7:0]  eqn;
        logic [7:0]  ern;
        if (exp_q.size() == 0) begin
            check("exp_q_empty", 32'd1, 32'd0);
            return;
        end
        e   = exp_q.pop_front();
        eqn = ~e[15:8];
        ern = ~e[7:0];
        check("q", q, e[15:8]);
        check("q_not", q_not, eqn);
        check("r", r, e[7:0]);
        check("r_not", r_not, ern);
        check("flags", {err_ovf, err_div0, err_rail}, e[18:16]);
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("valid_clr", out_valid, 1'b0);
        check("ready_next", in_ready, 1'b1);
        check("q_clr_not", q_not, 8'hFF);
        check("flags_clr", {err_ovf, err_div0, err_rail}, 3'b000);
    endtask

    // driver: launch one word at a negedge, then scramble inputs after accept
    task automatic launch(input logic [15:0] pv, input logic [15:0] pnv,
                          input logic [7:0] bv, input logic [7:0] bnv,
                          input logic [7:0] eq, input logic [7:0] er, input logic [2:0] ef);
        check("ready_pre", in_ready, 1'b1);
        p        = pv;
        p_not    = pnv;
        b        = bv;
        b_not    = bnv;
        in_valid = 1'b1;
        exp_q.push_back({ef, eq, er});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        p        = 16'($urandom);
        p_not    = 16'($urandom);
        b        = 8'($urandom);
        b_not    = 8'($urandom);
    endtask

    task automatic run_op(input logic [15:0] pv, input logic [15:0] pnv,
                          input logic [7:0] bv, input logic [7:0] bnv,
                          input logic [7:0] eq, input logic [7:0] er,
                          input logic [2:0] ef, input int elat);
        int lat;
        launch(pv, pnv, bv, bnv, eq, er, ef);
        wait_result(lat);
        check("latency", lat, elat);
        check_result();
        handshake();
    endtask

    initial begin
        int lat;
        int seen;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        p         = 16'd0;
        p_not     = 16'hFFFF;
        b         = 8'd0;
        b_not     = 8'hFF;
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_q", q, 8'h00);
        check("rst_q_not", q_not, 8'hFF);
        check("rst_r_not", r_not, 8'hFF);
        check("rst_flags", {err_ovf, err_div0, err_rail}, 3'b000);
        rst = 1'b0;
        @(negedge clk);
        check("rel_in_ready", in_ready, 1'b1);
        check("idle_out_ready", out_valid, 1'b0);
        out_ready = 1'b0;

        // Exact, remainder, and extremes (hand-computed)
        run_op(16'h159F, ~16'h159F, 8'h2D, ~8'h2D, 8'h7B, 8'h00, 3'b000, 9);
        run_op(16'h03E8, ~16'h03E8, 8'h07, ~8'h07, 8'h8E, 8'h06, 3'b000, 9);
        run_op(16'hFE01, ~16'hFE01, 8'hFF, ~8'hFF, 8'hFF, 8'h00, 3'b000, 9);
        run_op(16'h00FF, ~16'h00FF, 8'h01, ~8'h01, 8'hFF, 8'h00, 3'b000, 9);
        run_op(16'h7FFF, ~16'h7FFF, 8'h80, ~8'h80, 8'hFF, 8'h7F, 3'b000, 9);
        run_op(16'h0005, ~16'h0005, 8'h09, ~8'h09, 8'h00, 8'h05, 3'b000, 9);
        run_op(16'hABCD, ~16'hABCD, 8'hC8, ~8'hC8, 8'hDB, 8'hB5, 3'b000, 9);

        // Error paths, rail beats div0 beats ovf
        run_op(16'h1234, ~16'h1234, 8'h00, ~8'h00, 8'h00, 8'h00, 3'b010, 1);
        run_op(16'hFF00, ~16'hFF00, 8'h10, ~8'h10, 8'h00, 8'h00, 3'b100, 1);
        run_op(16'h0100, ~16'h0100, 8'h01, ~8'h01, 8'h00, 8'h00, 3'b100, 1);
        run_op(16'h0008, 16'hFFFF, 8'h00, ~8'h00, 8'h00, 8'h00, 3'b001, 1);
        run_op(16'hFF00, ~16'hFF00, 8'h10, 8'hEE, 8'h00, 8'h00, 3'b001, 1);

        // Backpressure with a new word waiting on in_valid
        launch(16'h159F, ~16'h159F, 8'h2D, ~8'h2D, 8'h7B, 8'h00, 3'b000);
        wait_result(lat);
        check("bp_latency", lat, 9);
        p        = 16'h03E8;
        p_not    = ~16'h03E8;
        b        = 8'h07;
        b_not    = ~8'h07;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", out_valid, 1'b1);
            check("bp_q", q, 8'h7B);
            check("bp_in_ready", in_ready, 1'b0);
        end
        check_result();
        out_ready = 1'b1;
        exp_q.push_back({3'b000, 8'h8E, 8'h06});
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_valid_clr", out_valid, 1'b0);
        check("bp_in_ready_next", in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_result(lat);
        check("bp2_latency", lat, 9);
        check_result();
        handshake();

        // Reset during CALC aborts the word
        check("rst_mid_ready", in_ready, 1'b1);
        p        = 16'h159F;
        p_not    = ~16'h159F;
        b        = 8'h2D;
        b_not    = ~8'h2D;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("pre_rst_state", dbg_state, 2'd2);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_in_ready", in_ready, 1'b0);
        check("mid_rst_valid", out_valid, 1'b0);
        check("mid_rst_q_not", q_not, 8'hFF);
        check("mid_rst_state", dbg_state, 2'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1'b1);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("aborted_no_valid", seen, 0);

        // Normal operation resumes after the abort
        run_op(16'h0064, ~16'h0064, 8'h0A, ~8'h0A, 8'h0A, 8'h00, 3'b000, 9);

        check("exp_q_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
